// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO bus arbiter.
package gpio_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // Register offsets of the GPIO block behind the shared port.
    localparam logic [3:0] GPIO_CTRL_OFS = 4'h0;
    localparam logic [3:0] GPIO_DATA_OFS = 4'h4;

    // Increment an index modulo n (n >= 1).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gpio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand;

    // Scan N positions starting at ptr_i, wrapping; the first set request wins.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((32'(ptr_i) + 32'(k)) % 32'(N));
            if (!valid_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO register port between N_MST masters,
// with per-master locking for atomic read-modify-write and a bounded lock time.
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int N_MST    = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_MST-1:0]    m_req_i,
    input  logic [N_MST-1:0]    m_we_i,
    input  logic [N_MST*AW-1:0] m_addr_i,
    input  logic [N_MST*DW-1:0] m_wdata_i,
    input  logic [N_MST-1:0]    m_lock_i,
    output logic [N_MST-1:0]    m_gnt_o,
    output logic [N_MST-1:0]    m_rvalid_o,
    output logic [DW-1:0]       m_rdata_o,
    output logic                gpio_we_o,
    output logic [AW-1:0]       gpio_addr_o,
    output logic [DW-1:0]       gpio_wdata_o,
    input  logic [DW-1:0]       gpio_rdata_i,
    output logic                lock_timeout_o
);

    localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int CW = $clog2(LOCK_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    // Masters whose lock was forcibly released; they may not relock until lock drops.
    logic [N_MST-1:0] relock_blk_q, relock_blk_d;
    logic [N_MST-1:0] rvalid_q;
    logic [DW-1:0]    rdata_q;

    logic [N_MST-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    logic [N_MST-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_valid;

    logic [AW-1:0]    addr_a  [N_MST];
    logic [DW-1:0]    wdata_a [N_MST];

    for (genvar m = 0; m < N_MST; m++) begin : g_unpack
        assign addr_a[m]  = m_addr_i[m*AW +: AW];
        assign wdata_a[m] = m_wdata_i[m*DW +: DW];
    end

    rr_pick #(
        .N  (N_MST),
        .IW (IW)
    ) u_pick (
        .req_i   (m_req_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Grant selection, lock tracking, forced release and pointer update.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        lock_cnt_d     = lock_cnt_q;
        relock_blk_d   = relock_blk_q & m_lock_i;
        gnt            = '0;
        gnt_idx        = '0;
        gnt_valid      = 1'b0;
        lock_timeout_o = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                gnt        = pick_gnt;
                gnt_idx    = pick_idx;
                gnt_valid  = pick_valid;
                lock_cnt_d = '0;
                if (pick_valid) begin
                    rr_ptr_d = IW'(wrap_inc(32'(pick_idx), N_MST));
                    if (m_lock_i[pick_idx] && !relock_blk_q[pick_idx]) begin
                        state_d = ARB_LOCKED;
                        owner_d = pick_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                // Only the owner may access; everyone else stalls.
                gnt_idx          = owner_q;
                gnt_valid        = m_req_i[owner_q];
                gnt[owner_q]     = m_req_i[owner_q];
                if (lock_cnt_q != CNT_LAST) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
                // A dropped lock wins over a simultaneous timeout.
                if (!m_lock_i[owner_q] || lock_cnt_q == CNT_LAST) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = IW'(wrap_inc(32'(owner_q), N_MST));
                    if (m_lock_i[owner_q]) begin
                        lock_timeout_o        = 1'b1;
                        relock_blk_d[owner_q] = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            lock_cnt_q   <= '0;
            relock_blk_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            relock_blk_q <= relock_blk_d;
        end
    end

    // Response register: one-cycle strobe to the granted master, read data or zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            // NOTE: the data register is reset as well so nothing stale is visible after reset.
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            rdata_q  <= (gnt_valid && !m_we_i[gnt_idx]) ? gpio_rdata_i : '0;
        end
    end

    assign m_gnt_o      = gnt;
    assign m_rvalid_o   = rvalid_q;
    assign m_rdata_o    = rdata_q;
    assign gpio_we_o    = gnt_valid & m_we_i[gnt_idx];
    assign gpio_addr_o  = gnt_valid ? addr_a[gnt_idx]  : '0;
    assign gpio_wdata_o = gnt_valid ? wdata_a[gnt_idx] : '0;

endmodule
